// File: rtl/st_fifo_pkg.sv
// Shared helpers for the streaming FIFO: ceiling log2 and the packet sideband
// record that travels alongside each payload word.
package st_fifo_pkg;

  typedef struct packed {
    logic sop;
    logic eop;
  } pkt_sb_t;

  localparam int SB_WIDTH = 2;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/st_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port. The array itself is never reset.
module st_fifo_ram #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read; a same-edge write to the read address forwards the new word
  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_r <= wr_data;
      end else begin
        rd_data_r <= mem_r[rd_addr];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/st_param_fifo.sv
// Parameterised streaming FIFO with packet sideband, fill level and threshold
// flags. The RAM read register doubles as the source output register.
module st_param_fifo
  import st_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2,
  parameter int USE_PACKETS  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_startofpacket,
  input  logic                    in_endofpacket,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic [clog2(DEPTH):0]   fill_level,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_WIDTH + SB_WIDTH;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic          almost_full_r;
  logic          almost_empty_r;

  logic          push_s;
  logic          pop_s;
  logic          rd_en_s;
  logic [CW-1:0] avail_s;
  logic [CW-1:0] count_nxt_s;
  logic          out_valid_nxt_s;
  pkt_sb_t       in_sb_s;
  pkt_sb_t       out_sb_s;
  logic [WW-1:0] wr_word_s;
  logic [WW-1:0] rd_word_s;

  // sideband is forced low when packets are not carried
  always_comb begin
    in_sb_s = '{sop: 1'b0, eop: 1'b0};
    if (USE_PACKETS != 0) begin
      in_sb_s.sop = in_startofpacket;
      in_sb_s.eop = in_endofpacket;
    end else begin
      in_sb_s = '{sop: 1'b0, eop: 1'b0};
    end
  end

  assign wr_word_s = {in_sb_s, in_data};

  // handshake decode, RAM prefetch and next fill level
  always_comb begin
    push_s          = in_valid & in_ready_r & ~flush;
    pop_s           = out_valid_r & out_ready & ~flush;
    // words sitting in the RAM that have not yet been loaded into the output
    avail_s         = count_r - {{AW{1'b0}}, out_valid_r};
    rd_en_s         = 1'b0;
    count_nxt_s     = count_r;
    out_valid_nxt_s = out_valid_r;
    if (flush) begin
      rd_en_s         = 1'b0;
      count_nxt_s     = {CW{1'b0}};
      out_valid_nxt_s = 1'b0;
    end else begin
      if (pop_s) begin
        // a concurrent write may refill the output directly when nothing else is stored
        rd_en_s         = (avail_s != {CW{1'b0}}) | push_s;
        out_valid_nxt_s = rd_en_s;
      end else if (!out_valid_r) begin
        rd_en_s         = (avail_s != {CW{1'b0}});
        out_valid_nxt_s = rd_en_s;
      end else begin
        rd_en_s         = 1'b0;
        out_valid_nxt_s = 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // pointers, fill level, flags and handshake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      out_valid_r    <= 1'b0;
      in_ready_r     <= 1'b0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (rd_en_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r        <= count_nxt_s;
      out_valid_r    <= out_valid_nxt_s;
      in_ready_r     <= (count_nxt_s != FULL_LVL);
      almost_full_r  <= (count_nxt_s >= AF_LVL);
      almost_empty_r <= (count_nxt_s <= AE_LVL);
    end
  end

  st_fifo_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_word_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_word_s)
  );

  // the unreset RAM register is masked so outputs read zero whenever nothing is presented
  assign out_sb_s          = pkt_sb_t'(rd_word_s[WW-1:DATA_WIDTH]);
  assign out_data          = out_valid_r ? rd_word_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign out_startofpacket = out_valid_r & out_sb_s.sop;
  assign out_endofpacket   = out_valid_r & out_sb_s.eop;

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign fill_level   = count_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;

endmodule

// File: tb/tb_st_param_fifo.sv
// Self-checking bench for st_param_fifo: directed vector table, hand-written
// corner sequences and a seeded random run against a queue-based model.
module tb_st_param_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [3:0]    fill_level;
  logic          almost_full;
  logic          almost_empty;

  st_param_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .fill_level        (fill_level),
    .almost_full       (almost_full),
    .almost_empty      (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // model: stored words {sop, eop, data} in order, plus presented flag and ready
  logic [DW+1:0] mq[$];
  logic          m_ov;
  logic          m_rdy;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_data;
    logic [3:0]    e_fill;
    logic          e_rdy;
    logic          e_af;
    logic          e_ae;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_model();
    logic [DW+1:0] head;
    chk("out_valid", {65'd0, out_valid}, {65'd0, m_ov});
    chk("fill_level", {62'd0, fill_level}, 66'(mq.size()));
    chk("in_ready", {65'd0, in_ready}, {65'd0, m_rdy});
    chk("almost_full", {65'd0, almost_full}, {65'd0, (mq.size() >= DEPTH - 2)});
    chk("almost_empty", {65'd0, almost_empty}, {65'd0, (mq.size() <= 2)});
    if (m_ov && mq.size() != 0) begin
      head = mq[0];
      chk("out_data", {2'b00, out_data}, {2'b00, head[DW-1:0]});
      chk("out_sop", {65'd0, out_startofpacket}, {65'd0, head[DW+1]});
      chk("out_eop", {65'd0, out_endofpacket}, {65'd0, head[DW]});
    end
  endtask

  // apply one clock of stimulus, advance the model by the stated rules, then compare
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic s, input logic e,
                       input logic ordy, input logic fl);
    logic push;
    logic pop;
    int   pre_size;
    in_valid         = iv;
    in_data          = d;
    in_startofpacket = s;
    in_endofpacket   = e;
    out_ready        = ordy;
    flush            = fl;
    push     = iv & m_rdy & ~fl;
    pop      = m_ov & ordy & ~fl;
    pre_size = mq.size();
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({s, e, d});
      // a popped word is replaced at once; otherwise only a previously stored word becomes visible
      if (pop) m_ov = (mq.size() != 0);
      else     m_ov = m_ov | (pre_size != 0);
    end
    m_rdy = (mq.size() < DEPTH);
    check_model();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    flush            = 1'b0;
    in_valid         = 1'b0;
    in_data          = 64'd0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    out_ready        = 1'b0;
    mq.delete();
    m_ov  = 1'b0;
    m_rdy = 1'b0;
    #3;
    chk("rst_in_ready", {65'd0, in_ready}, 66'd0);
    chk("rst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("rst_fill", {62'd0, fill_level}, 66'd0);
    chk("rst_almost_empty", {65'd0, almost_empty}, 66'd1);
    chk("rst_almost_full", {65'd0, almost_full}, 66'd0);
    chk("rst_out_data", {2'b00, out_data}, 66'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    reset = 1'b1;
    do_reset();

    // table: fill 0..7, one refused write while full, then drain
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{iv: 1'b1, d: 64'(i), ordy: 1'b0, e_ov: (i >= 1), e_data: 64'd0,
                  e_fill: 4'(i + 1), e_rdy: (i + 1 < 8), e_af: (i + 1 >= 6), e_ae: (i + 1 <= 2)};
    end
    vecs[8] = '{iv: 1'b1, d: 64'd99, ordy: 1'b0, e_ov: 1'b1, e_data: 64'd0,
                e_fill: 4'd8, e_rdy: 1'b0, e_af: 1'b1, e_ae: 1'b0};
    for (int j = 0; j < 8; j++) begin
      vecs[9 + j] = '{iv: 1'b0, d: 64'd0, ordy: 1'b1, e_ov: (j < 7), e_data: 64'(j + 1),
                      e_fill: 4'(7 - j), e_rdy: 1'b1, e_af: (7 - j >= 6), e_ae: (7 - j <= 2)};
    end
    for (int k = 0; k < 17; k++) begin
      cycle(vecs[k].iv, vecs[k].d, 1'b0, 1'b0, vecs[k].ordy, 1'b0);
      chk($sformatf("tbl%0d_ov", k), {65'd0, out_valid}, {65'd0, vecs[k].e_ov});
      chk($sformatf("tbl%0d_fill", k), {62'd0, fill_level}, {62'd0, vecs[k].e_fill});
      chk($sformatf("tbl%0d_rdy", k), {65'd0, in_ready}, {65'd0, vecs[k].e_rdy});
      chk($sformatf("tbl%0d_af", k), {65'd0, almost_full}, {65'd0, vecs[k].e_af});
      chk($sformatf("tbl%0d_ae", k), {65'd0, almost_empty}, {65'd0, vecs[k].e_ae});
      if (vecs[k].e_ov) chk($sformatf("tbl%0d_data", k), {2'b00, out_data}, {2'b00, vecs[k].e_data});
    end

    // two-edge latency into an empty FIFO
    cycle(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_k_valid", {65'd0, out_valid}, 66'd0);
    idle(1'b0);
    chk("lat_k1_valid", {65'd0, out_valid}, 66'd1);
    chk("lat_k1_data", {2'b00, out_data}, 66'hA5);
    idle(1'b1);

    // three-word packet markers
    cycle(1'b1, 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h101, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h102, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pkt0_sop", {65'd0, out_startofpacket}, 66'd1);
    chk("pkt0_eop", {65'd0, out_endofpacket}, 66'd0);
    idle(1'b1);
    chk("pkt1_sop", {65'd0, out_startofpacket}, 66'd0);
    chk("pkt1_eop", {65'd0, out_endofpacket}, 66'd0);
    idle(1'b1);
    chk("pkt2_data", {2'b00, out_data}, 66'h102);
    chk("pkt2_eop", {65'd0, out_endofpacket}, 66'd1);
    idle(1'b1);

    // read and write together at fill level 1
    cycle(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rw1_valid", {65'd0, out_valid}, 66'd1);
    chk("rw1_data", {2'b00, out_data}, 66'h22);
    chk("rw1_fill", {62'd0, fill_level}, 66'd1);
    idle(1'b1);

    // flush at fill level 5 with a concurrent write
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(i + 'h50), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_fill", {62'd0, fill_level}, 66'd5);
    cycle(1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_fill", {62'd0, fill_level}, 66'd0);
    chk("flush_valid", {65'd0, out_valid}, 66'd0);
    chk("flush_ready", {65'd0, in_ready}, 66'd1);
    cycle(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("post_flush_data", {2'b00, out_data}, 66'h77);
    idle(1'b1);

    // random traffic, seed 23
    void'($urandom(23));
    for (int n = 0; n < 200; n++) begin
      rd = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
    end
    for (int n = 0; n < 10; n++) idle(1'b1);

    // asynchronous reset between edges with fill level 4
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'(i + 'h30), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_arst_fill", {62'd0, fill_level}, 66'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {65'd0, out_valid}, 66'd0);
    chk("arst_fill", {62'd0, fill_level}, 66'd0);
    chk("arst_data", {2'b00, out_data}, 66'd0);
    do_reset();
    cycle(1'b1, 64'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/st_param_fifo.md
ST_PARAM_FIFO -- requirements
Module: st_param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width in bits (1..512).
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 4.
REQ-003 SHALL have parameter ALMOST_FULL, default DEPTH-2, fill_level at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY, default 2, fill_level at or below which almost_empty asserts.
REQ-005 SHALL have parameter USE_PACKETS, default 1, carries sop/eop sideband when 1; sideband tied to 0 when 0.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-009 SHALL have port in_valid  input  1  sink word present.
REQ-010 SHALL have port in_ready  output  1  sink may accept.
REQ-011 SHALL have port in_data  input  DATA_WIDTH  sink payload.
REQ-012 SHALL have port in_startofpacket / in_endofpacket  input  1 each  sink packet markers.
REQ-013 SHALL have port out_valid  output  1  source word present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  source payload.
REQ-016 SHALL have port out_startofpacket / out_endofpacket  output  1 each  source packet markers.
REQ-017 SHALL have port fill_level  output  clog2(DEPTH)+1  stored entry count, 0..DEPTH.
REQ-018 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.

Function
REQ-019 Write accepted on a rising edge where in_valid & in_ready & !flush; read on edge where out_valid & out_ready & !flush.
REQ-020 in_ready SHALL equal !full, driven from a register (no combinational path from out_ready).
REQ-021 Word accepted at edge k into an empty FIFO SHALL present out_valid=1 with its data after edge k+1 (two-edge latency); no bubble thereafter while non-empty.
REQ-022 out_data/out_sop/out_eop SHALL be registered and stable while out_valid & !out_ready.
REQ-023 Order SHALL be strict FIFO; sop/eop travel with their data word unchanged.
REQ-024 fill_level SHALL be registered: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-025 Full (fill_level==DEPTH): in_ready=0; concurrent read SHALL raise in_ready after that edge, write not accepted in the same cycle.
REQ-026 Empty: out_valid=0; in_valid ignored for read purposes; no underflow of pointers.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full/empty disambiguated by fill_level, not pointer equality.
REQ-028 Simultaneous read+write at fill_level 1 SHALL keep out_valid=1 continuously with the new word following.
REQ-029 almost_full = (fill_level >= ALMOST_FULL), almost_empty = (fill_level <= ALMOST_EMPTY), both registered, updated same edge as fill_level.
REQ-030 flush high at edge k SHALL zero pointers and fill_level, drop any concurrent write/read, and give out_valid=0 after edge k; in_ready=1 after edge k.

Reset
REQ-031 reset high SHALL immediately force: in_ready=0 while asserted, out_valid=0, fill_level=0, almost_empty=1, almost_full=0, pointers=0, out_data/sop/eop=0.
REQ-032 in_ready SHALL rise on the first rising edge after reset deasserts; reset mid-transfer discards all contents; memory array is not reset.

Structure
REQ-033 A shared package st_fifo_pkg SHALL hold the clog2 function and the packet-sideband struct (sop, eop).
REQ-034 Storage SHALL be one sub-module st_fifo_ram: simple dual-port, one write port, one registered read port, DEPTH x (DATA_WIDTH+2), no reset.
REQ-035 Pointer, count, flag and output-register logic SHALL reside in st_param_fifo.

Verification (DATA_WIDTH=64, DEPTH=8, defaults otherwise)
REQ-036 Fill: out_ready=0, write 0..7 back-to-back -> in_ready=0 after 8th accept, fill_level=8, almost_full=1 from level 6.
REQ-037 Drain: out_ready=1 from full -> outputs 0..7 in order, one per cycle, out_valid=0 and fill_level=0 after 8th read, almost_empty=1 from level 2.
REQ-038 Latency: single write of 0xA5 into empty at edge k -> out_valid=1, out_data=0xA5 after edge k+1.
REQ-039 Packets: 3-word packet sop on word0, eop on word2 -> identical markers on output; 200 random in_valid/out_ready cycles with seed 23 -> no loss, no reorder, fill_level always matches model.
REQ-040 Flush with fill_level=5 plus concurrent write -> fill_level=0, out_valid=0 next cycle; next written word 0x77 is first out.
REQ-041 Async reset asserted mid-cycle with fill_level=4 -> out_valid=0, fill_level=0 immediately, before any clock edge.
